// File: rtl/iob_wishbone_arbiter_pkg.sv
// iob_wishbone_arbiter_pkg: FSM encoding, default watchdog width and
// the rotate-and-priority-encode helper shared by the arbiter files.
package iob_wishbone_arbiter_pkg;

  localparam int TIMEOUT_W_DEF = 8;
  localparam int MAX_REQ       = 8;
  localparam int PICK_W        = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } pick_t;

  // First set bit of req at or after ptr, scanning upward mod n.
  function automatic pick_t rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [PICK_W-1:0]  ptr,
    input int unsigned        n
  );
    pick_t       r;
    int unsigned k;
    r = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      k = (32'(ptr) + i) % n;
      if (!r.found && (i < n) && req[PICK_W'(k)]) begin
        r.found = 1'b1;
        r.idx   = PICK_W'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/iob_wishbone_arbiter_rr.sv
// iob_rr_arbiter: combinational round-robin pick over N_REQ requests.
// Ports: req_i, ptr_i, en_i in; one-hot grant_o, binary idx_o, any_o out.
module iob_rr_arbiter
  import iob_wishbone_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [MAX_REQ-1:0] req_pad;
  pick_t              pick;

  always_comb begin
    req_pad            = '0;
    req_pad[N_REQ-1:0] = req_i;
    pick  = rr_pick(req_pad, PICK_W'(ptr_i), N_REQ);
    any_o = en_i && pick.found;
    idx_o = IDX_W'(pick.idx);
    grant_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant_o[i] = any_o && (pick.idx == PICK_W'(i));
    end
  end

endmodule

// File: rtl/iob_wishbone_arbiter.sv
// iob_wishbone_arbiter: round-robin share of one Wishbone classic master
// between N_REQ IOb requesters, grant locked per transaction, watchdog.
// Ports: clk_i, rst_i (sync, high); IOb side valid_i/address_i/wdata_i/
// wstrb_i in, rdata_o/ready_o/err_o out; Wishbone wb_* master, all
// outputs registered.
module iob_wishbone_arbiter
  import iob_wishbone_arbiter_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_REQ-1:0]           valid_i,
  input  logic [N_REQ*ADDR_W-1:0]    address_i,
  input  logic [N_REQ*DATA_W-1:0]    wdata_i,
  input  logic [N_REQ*DATA_W/8-1:0]  wstrb_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [N_REQ-1:0]           ready_o,
  output logic [N_REQ-1:0]           err_o,
  output logic [ADDR_W-1:0]          wb_addr_o,
  output logic [DATA_W/8-1:0]        wb_select_o,
  output logic                       wb_we_o,
  output logic                       wb_cyc_o,
  output logic                       wb_stb_o,
  output logic [DATA_W-1:0]          wb_data_o,
  input  logic                       wb_ack_i,
  input  logic                       wb_error_i,
  input  logic [DATA_W-1:0]          wb_data_i
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int STRB_W = DATA_W / 8;

  // Watchdog fires on the BUS cycle where the counter steps to all-ones.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST =
    {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [STRB_W-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [N_REQ-1:0]    ready_q, ready_d;
  logic [N_REQ-1:0]    err_q, err_d;

  logic [N_REQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;

  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [STRB_W-1:0]   sel_wstrb;
  logic                done;
  logic                fail;

  iob_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i   (valid_i),
    .ptr_i   (ptr_q),
    .en_i    (state_q == IDLE),
    .grant_o (arb_gnt),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_addr  = address_i[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata_i[i*DATA_W +: DATA_W];
        sel_wstrb = wstrb_i[i*STRB_W +: STRB_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    ready_d = '0;
    err_d   = '0;
    done    = 1'b0;
    fail    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          gidx_d  = arb_idx;
          addr_d  = sel_addr & ~ADDR_W'(3);
          we_d    = |sel_wstrb;
          sel_d   = we_d ? sel_wstrb : '1;
          wdat_d  = sel_wdata;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        cnt_d = cnt_q + TIMEOUT_W'(1);
        if (wb_error_i) begin
          done = 1'b1;
          fail = 1'b1;
        end else if (wb_ack_i) begin
          done = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          done = 1'b1;
          fail = 1'b1;
        end
        if (done) begin
          cyc_d           = 1'b0;
          rdata_d         = (fail || we_q) ? '0 : wb_data_i;
          ready_d[gidx_q] = 1'b1;
          err_d[gidx_q]   = fail;
          state_d         = RESP;
        end
      end
      RESP: begin
        ptr_d   = (gidx_q == IDX_LAST) ? '0 : gidx_q + IDX_W'(1);
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      ready_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign rdata_o     = rdata_q;
  assign ready_o     = ready_q;
  assign err_o       = err_q;
  assign wb_addr_o   = addr_q;
  assign wb_select_o = sel_q;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_data_o   = wdat_q;

endmodule
